// File: rtl/riscv_loader_pkg.sv
// rtl/riscv_loader_pkg.sv - shared types and status bit positions for the imem loader
package riscv_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_RUNNING   = 1;
  localparam int STATUS_ERR_ALIGN = 2;
  localparam int STATUS_ERR_RANGE = 3;
  localparam int STATUS_ERR_BUSY  = 4;
  localparam int LDCNT_LSB        = 16;

endpackage

// File: rtl/loader_edge_det.sv
// rtl/loader_edge_det.sv - rising-edge detector for software strobe bits
module loader_edge_det #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  // Remember last cycle's strobe levels; cleared so a held strobe fires once after reset
  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/riscv_imem_loader.sv
// rtl/riscv_imem_loader.sv - software-driven instruction memory loader, clear sweep and run gate
import riscv_loader_pkg::*;

module riscv_imem_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int CNT_W      = 16,
  localparam int AW        = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instruction_write,
  input  logic [31:0]   instruction_data,
  input  logic [31:0]   instruction_addr,
  input  logic          mem_reset_n,
  input  logic          run_pc_in,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_run,
  output logic [31:0]   loader_status
);

  loader_state_t    state, state_n;
  logic [1:0]       strobe_rise;
  logic             load_edge, errclr_edge;
  logic             clear_req, misaligned, out_of_range, sweep_more;
  logic             sweeping, sweeping_n;
  logic             we_n;
  logic [AW-1:0]    waddr_n;
  logic [31:0]      wdata_n;
  logic [CNT_W-1:0] load_count;
  logic             err_align, err_range, err_busy, run_armed, busy, running;
  logic             unused_write_bits;

  loader_edge_det #(.WIDTH(2)) u_strobe_edge (
    .clk   (clk),
    .reset (reset),
    .din   (instruction_write[1:0]),
    .rise  (strobe_rise)
  );

  assign load_edge         = strobe_rise[0];
  assign errclr_edge       = strobe_rise[1];
  assign unused_write_bits = ^instruction_write[31:2];

  // A clear request only restarts the sweep when not already clearing
  assign clear_req    = ~mem_reset_n && (state != CLEAR);
  assign misaligned   = |instruction_addr[1:0];
  assign out_of_range = (instruction_addr >> (AW + 2)) != 32'd0;
  // The write address register doubles as the sweep index while clearing
  assign sweep_more   = sweeping && (imem_waddr != AW'(IMEM_DEPTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic, priority clear > write > run
  always_comb begin
    state_n = state;
    if (clear_req) begin
      state_n = CLEAR;
    end else begin
      case (state)
        IDLE: begin
          if (load_edge) begin
            if (!misaligned && !out_of_range) state_n = WRITE;
          end else if (run_pc_in && run_armed) begin
            state_n = RUN;
          end
        end
        WRITE:   state_n = IDLE;
        CLEAR:   if (!sweep_more && mem_reset_n) state_n = IDLE;
        RUN:     if (!run_pc_in) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Next values of the registered write port; address/data hold when no write is issued
  always_comb begin
    we_n       = 1'b0;
    waddr_n    = imem_waddr;
    wdata_n    = imem_wdata;
    sweeping_n = 1'b0;
    if (clear_req) begin
      we_n       = 1'b1;
      waddr_n    = '0;
      wdata_n    = '0;
      sweeping_n = 1'b1;
    end else if (state == CLEAR && sweep_more) begin
      we_n       = 1'b1;
      waddr_n    = imem_waddr + AW'(1);
      wdata_n    = '0;
      sweeping_n = 1'b1;
    end else if (state_n == WRITE) begin
      we_n       = 1'b1;
      waddr_n    = instruction_addr[AW+1:2];
      wdata_n    = instruction_data;
    end
  end

  // Datapath, flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      sweeping   <= 1'b0;
      busy       <= 1'b0;
      running    <= 1'b0;
      core_run   <= 1'b0;
      load_count <= '0;
      err_align  <= 1'b0;
      err_range  <= 1'b0;
      err_busy   <= 1'b0;
      run_armed  <= 1'b1;
    end else begin
      imem_we    <= we_n;
      imem_waddr <= waddr_n;
      imem_wdata <= wdata_n;
      sweeping   <= sweeping_n;
      busy       <= (state_n == WRITE) || (state_n == CLEAR);
      running    <= (state_n == RUN);
      core_run   <= (state_n == RUN);

      if (clear_req)                                     load_count <= '0;
      else if (state == WRITE && load_count != '1)       load_count <= load_count + CNT_W'(1);

      if (state == IDLE && !clear_req && load_edge && misaligned)
        err_align <= 1'b1;
      else if (errclr_edge)
        err_align <= 1'b0;

      if (state == IDLE && !clear_req && load_edge && !misaligned && out_of_range)
        err_range <= 1'b1;
      else if (errclr_edge)
        err_range <= 1'b0;

      if (load_edge && (clear_req || state != IDLE))
        err_busy <= 1'b1;
      else if (errclr_edge)
        err_busy <= 1'b0;

      // A clear must not let a still-high run request restart the core by itself
      if (!run_pc_in)                               run_armed <= 1'b1;
      else if (state == CLEAR && state_n != CLEAR)  run_armed <= 1'b0;
    end
  end

  // Status word for software readback
  always_comb begin
    loader_status                          = '0;
    loader_status[STATUS_BUSY]             = busy;
    loader_status[STATUS_RUNNING]          = running;
    loader_status[STATUS_ERR_ALIGN]        = err_align;
    loader_status[STATUS_ERR_RANGE]        = err_range;
    loader_status[STATUS_ERR_BUSY]         = err_busy;
    loader_status[31:LDCNT_LSB]            = 16'(load_count);
  end

endmodule
